// File: rtl/tdm_mux8to1.sv
// tdm_mux8to1: 8-channel TDM transmitter. Captures an 8-bit channel word and
// sends it one bit per slot with the slot index, so a 1-to-8 demux can route
// each bit back to its channel.
//
// Handshake: a bit is transferred on a rising edge where valid=1 and ready=1.
// While valid=1 and ready=0, Y/sel/valid/sof hold unchanged with no timeout.
module tdm_mux8to1 #(
    parameter bit CONTINUOUS   = 1'b0,
    parameter bit SOF_ON_SLOT0 = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] D,
    input  logic       ready,
    output logic       Y,
    output logic [2:0] sel,
    output logic       valid,
    output logic       sof,
    output logic       busy,
    output logic       done,
    output logic       dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_shadow;
    logic [2:0] r_slot;
    logic       r_y;
    logic       r_valid;
    logic       r_sof;
    logic       r_busy;
    logic       r_done;

    state_t     w_state;
    logic [7:0] w_shadow;
    logic [2:0] w_slot;
    logic [2:0] w_slot_inc;
    logic       w_y;
    logic       w_valid;
    logic       w_sof;
    logic       w_busy;
    logic       w_done;

    assign w_slot_inc = r_slot + 3'd1;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state  = r_state;
        w_shadow = r_shadow;
        w_slot   = r_slot;
        w_y      = r_y;
        w_valid  = r_valid;
        w_sof    = r_sof;
        w_busy   = r_busy;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state  = ST_SEND;
                    w_shadow = D;
                    w_slot   = 3'd0;
                    w_y      = D[0];
                    w_valid  = 1'b1;
                    w_sof    = SOF_ON_SLOT0;
                    w_busy   = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_valid && ready) begin
                    if (r_slot != 3'd7) begin
                        w_slot = w_slot_inc;
                        w_y    = r_shadow[w_slot_inc];
                        w_sof  = 1'b0;
                    end else begin
                        w_done = 1'b1;
                        if (CONTINUOUS && !stop) begin
                            // Back-to-back frame: recapture on the same edge, no gap.
                            w_shadow = D;
                            w_slot   = 3'd0;
                            w_y      = D[0];
                            w_sof    = SOF_ON_SLOT0;
                        end else begin
                            w_state = ST_IDLE;
                            w_slot  = 3'd0;
                            w_y     = 1'b0;
                            w_valid = 1'b0;
                            w_sof   = 1'b0;
                            w_busy  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shadow <= 8'd0;
            r_slot   <= 3'd0;
            r_y      <= 1'b0;
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shadow <= w_shadow;
            r_slot   <= w_slot;
            r_y      <= w_y;
            r_valid  <= w_valid;
            r_sof    <= w_sof;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign Y         = r_y;
    assign sel       = r_slot;
    assign valid     = r_valid;
    assign sof       = r_sof;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tdm_mux8to1.sv
// Directed bench for tdm_mux8to1: a single-frame instance and a
// continuous-framing instance, plus a small demux model for loopback.
module tb_tdm_mux8to1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] d;
    logic       ready;
    logic       y;
    logic [2:0] sel;
    logic       valid;
    logic       sof;
    logic       busy;
    logic       done;
    logic       dbg;

    logic       c_start;
    logic       c_stop;
    logic [7:0] c_d;
    logic       c_ready;
    logic       c_y;
    logic [2:0] c_sel;
    logic       c_valid;
    logic       c_sof;
    logic       c_busy;
    logic       c_done;
    logic       c_dbg;

    logic       lb_clr;
    logic [7:0] lb_q;

    int n_checks;
    int n_errors;

    tdm_mux8to1 #(.CONTINUOUS(1'b0), .SOF_ON_SLOT0(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .D(d),
        .ready(ready), .Y(y), .sel(sel), .valid(valid), .sof(sof),
        .busy(busy), .done(done), .dbg_state(dbg)
    );

    tdm_mux8to1 #(.CONTINUOUS(1'b1), .SOF_ON_SLOT0(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .stop(c_stop), .D(c_d),
        .ready(c_ready), .Y(c_y), .sel(c_sel), .valid(c_valid), .sof(c_sof),
        .busy(c_busy), .done(c_done), .dbg_state(c_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Demux model: latch each accepted bit into its slot position.
    always @(posedge clk) begin
        if (lb_clr) lb_q <= 8'd0;
        else if (valid && ready) lb_q[sel] <= y;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk one single-frame transfer on u_dut (frame already started).
    task automatic frame_expect(input logic [7:0] w, input int stall_at, input int stall_n,
                                input bit poke);
        for (int s = 0; s < 8; s++) begin
            if (s == stall_at) begin
                ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    step();
                    check("stall_valid", 32'(valid), 32'd1);
                    check("stall_sel", 32'(sel), s);
                    check("stall_y", 32'(y), 32'(w[s]));
                end
                ready = 1'b1;
            end
            if (poke && s == 2) begin
                d = 8'hFF;
                start = 1'b1;
            end
            check("f_valid", 32'(valid), 32'd1);
            check("f_sel", 32'(sel), s);
            check("f_y", 32'(y), 32'(w[s]));
            check("f_sof", 32'(sof), 32'(s == 0));
            check("f_busy", 32'(busy), 32'd1);
            check("f_done", 32'(done), 32'd0);
            step();
            start = 1'b0;
        end
        check("end_done", 32'(done), 32'd1);
        check("end_valid", 32'(valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_sel", 32'(sel), 32'd0);
        check("end_y", 32'(y), 32'd0);
        step();
        check("end_done_pulse", 32'(done), 32'd0);
        check("end_state", 32'(dbg), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] w);
        d = w;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; d = 8'h00; ready = 1'b1;
        c_start = 1'b0; c_stop = 1'b0; c_d = 8'h00; c_ready = 1'b1;
        lb_clr = 1'b1;
        repeat (3) step();

        // Reset values
        check("rst_y", 32'(y), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        lb_clr = 1'b0;
        step();

        // stop alone in IDLE does nothing
        stop = 1'b1;
        step();
        check("idle_stop_valid", 32'(valid), 32'd0);
        check("idle_stop_busy", 32'(busy), 32'd0);
        stop = 1'b0;

        // Plain frame, ready high
        start_frame(8'b1010_0110);
        frame_expect(8'b1010_0110, -1, 0, 1'b0);

        // Same frame with a 3-cycle stall at slot 3
        start_frame(8'b1010_0110);
        frame_expect(8'b1010_0110, 3, 3, 1'b0);

        // D changed to FF and start pulsed at slot 2: no effect on frame
        start_frame(8'b1010_0110);
        frame_expect(8'b1010_0110, -1, 0, 1'b1);
        check("no_queued_frame", 32'(valid), 32'd0);

        // Continuous framing: 0F then F0, stop on last slot of frame 2
        c_d = 8'h0F;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 8; s++) begin
                logic [7:0] w;
                w = (f == 0) ? 8'h0F : 8'hF0;
                check("c_valid", 32'(c_valid), 32'd1);
                check("c_sel", 32'(c_sel), s);
                check("c_y", 32'(c_y), 32'(w[s]));
                check("c_sof", 32'(c_sof), 32'(s == 0));
                check("c_done", 32'(c_done), 32'(s == 0 && f == 1));
                if (s == 7) begin
                    if (f == 0) c_d = 8'hF0;
                    else c_stop = 1'b1;
                end
                step();
            end
        end
        check("c_end_done", 32'(c_done), 32'd1);
        check("c_end_valid", 32'(c_valid), 32'd0);
        check("c_end_busy", 32'(c_busy), 32'd0);
        check("c_end_sof", 32'(c_sof), 32'd0);
        c_stop = 1'b0;
        step();
        check("c_done_pulse", 32'(c_done), 32'd0);
        check("c_idle", 32'(c_valid), 32'd0);

        // Reset at slot 5
        start_frame(8'b1010_0110);
        repeat (5) step();
        check("pre_rst_sel", 32'(sel), 32'd5);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_valid", 32'(valid), 32'd0);
        start_frame(8'b1010_0110);
        frame_expect(8'b1010_0110, -1, 0, 1'b0);

        // Loopback through demux model
        lb_clr = 1'b1;
        step();
        lb_clr = 1'b0;
        start_frame(8'h5A);
        repeat (9) step();
        check("loop_5a", 32'(lb_q), 32'h5A);
        lb_clr = 1'b1;
        step();
        lb_clr = 1'b0;
        start_frame(8'hC3);
        repeat (9) step();
        check("loop_c3", 32'(lb_q), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_mux8to1.md
Name: tdm_mux8to1

Overview:
- 8-channel time-division multiplexer: the transmit end that pairs with the 1-to-8 demux.
- On start, snapshots an 8-bit channel word and serialises it one bit per slot onto a single line.
- Each bit is sent with its 3-bit slot select, so a downstream demux1to8 can route bit k back to output k.
- Valid/ready handshake on the serial side; optional back-to-back continuous framing.

Parameters:
CONTINUOUS, 0, 1 = re-capture D and start a new frame immediately after slot 7 until stop is seen; 0 = single frame per start
SOF_ON_SLOT0, 1, 1 = sof asserted with slot 0; 0 = sof held low

Ports:
clk     in   1  system clock, rising edge
rst_n   in   1  asynchronous active-low reset
start   in   1  begin frame; sampled only in IDLE
stop    in   1  end continuous streaming; sampled at frame end
D       in   8  parallel channel word; D[k] is channel k
ready   in   1  downstream accepts current bit
Y       out  1  serial data bit = captured D[sel]
sel     out  3  slot index of Y, 0..7
valid   out  1  Y/sel valid
sof     out  1  start-of-frame, high with slot 0
busy    out  1  frame in progress
done    out  1  one-cycle pulse after slot 7 accepted

Behaviour:
- All outputs registered.
- Reset (rst_n=0, async): state=IDLE; Y=0, sel=0, valid=0, sof=0, busy=0, done=0; shadow register=0, slot counter=0.
- FSM states: IDLE, SEND.
- IDLE:
  - valid=0, busy=0.
  - start=1 at an edge: shadow<=D, slot<=0, go SEND.
  - Next cycle: valid=1, sel=0, Y=D[0] as captured, sof=1 (if SOF_ON_SLOT0), busy=1. Start-to-valid latency is 1 cycle.
- SEND, handshake:
  - A transfer occurs on an edge with valid=1 and ready=1.
  - ready=0: Y, sel, valid, sof hold unchanged. No slot advance, no timeout.
  - Transfer at slot s<7: slot<=s+1, Y<=shadow[s+1], sof<=0.
- SEND, transfer at slot 7 (frame end):
  - done=1 for exactly the next cycle.
  - CONTINUOUS=0, or CONTINUOUS=1 with stop=1 on that edge: go IDLE; valid, busy, sel go to 0.
  - CONTINUOUS=1 and stop=0: shadow<=D on that same edge, slot<=0, sof=1, valid stays 1. No idle gap; done and sof coincide.
- D changes during SEND have no effect on the current frame; shadow is captured only at frame start.
- start while in SEND is ignored; no queuing.
- stop is sampled only on the slot-7 transfer edge.
- In IDLE with start=0, stop has no effect.
- With ready tied high, a frame takes exactly 8 valid cycles; done appears on cycle 9 after the first valid.
- Slot counter is 3 bits and never wraps except via the frame-end rule.
- Reset mid-frame: immediate return to reset values; no done pulse; next frame requires a new start.
- Y is 0 whenever valid=0.

Test Plan:
- Reset, then D=8'b1010_0110, start pulse, ready=1 -> Y sequence slot0..7 = 0,1,1,0,0,1,0,1; sel 0..7; sof only at sel=0; done one cycle after sel=7; busy low afterwards.
- Same frame with ready=0 for 3 cycles at sel=3 -> Y=0, sel=3, valid=1 held for 3 cycles; frame completes with the correct bit order.
- D changed to 8'hFF at sel=2 mid-frame -> remaining bits still follow the originally captured 8'b1010_0110; start pulse mid-frame ignored.
- CONTINUOUS=1, D=8'h0F then 8'hF0, stop low -> frame 2 sel=0 follows frame 1 sel=7 with no gap; done and sof coincide; stop=1 on the last slot of frame 2 -> IDLE.
- rst_n dropped at sel=5 -> outputs zero asynchronously, no done; a fresh start restarts from sel=0.
- Loopback into demux1to8 (D=Y, sel=sel): latched per-slot outputs reconstruct the original 8-bit word for 8'h5A and 8'hC3.
